// File: rtl/serial_port.sv
// Link-cable serial responder: SB/SC registers on the CPU bus and an 8-bit
// MSB-first shifter clocked internally (CLOCK_DIV) or from an external pin.
module serial_port #(
  parameter int CLOCK_DIV = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_addr,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  mem_data_out,
  output logic        irq,
  output logic        serial_clk_out,
  input  logic        serial_clk_in,
  output logic        serial_data_out,
  input  logic        serial_data_in
);

  localparam logic [9:0] PHASE_RISE = 10'(CLOCK_DIV / 2);
  localparam logic [9:0] PHASE_LAST = 10'(CLOCK_DIV - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t     state;
  logic [7:0] sb;
  logic       sc0;
  logic [9:0] phase;
  logic [3:0] bit_cnt;
  // [0],[1] synchronize the external clock; [2] holds the previous value
  logic [2:0] clk_sync;

  logic hit_sb, hit_sc, wr_sb, wr_sc, rd_hit;
  logic ext_rise, ext_fall, fall_evt, rise_evt;

  always_comb begin
    hit_sb   = mem_enable && (mem_addr == 16'hFF01);
    hit_sc   = mem_enable && (mem_addr == 16'hFF02);
    wr_sb    = hit_sb && mem_write;
    wr_sc    = hit_sc && mem_write;
    rd_hit   = (hit_sb || hit_sc) && !mem_write;
    ext_rise = clk_sync[1] && !clk_sync[2];
    ext_fall = !clk_sync[1] && clk_sync[2];
    fall_evt = (state == SHIFT) && (sc0 ? (phase == 10'd0) : ext_fall);
    rise_evt = (state == SHIFT) && (sc0 ? (phase == PHASE_RISE) : ext_rise);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      sb              <= 8'h00;
      sc0             <= 1'b0;
      phase           <= 10'd0;
      bit_cnt         <= 4'd0;
      clk_sync        <= 3'b111;
      mem_data_out    <= 8'h00;
      irq             <= 1'b0;
      serial_clk_out  <= 1'b1;
      serial_data_out <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[1:0], serial_clk_in};
      irq      <= 1'b0;

      if (rd_hit)
        mem_data_out <= hit_sb ? sb : {state == SHIFT, 6'b111111, sc0};

      if (state == SHIFT) begin
        if (sc0)
          phase <= (phase == PHASE_LAST) ? 10'd0 : phase + 10'd1;
        if (fall_evt) begin
          serial_data_out <= sb[7];
          if (sc0)
            serial_clk_out <= 1'b0;
        end
        if (rise_evt) begin
          sb             <= {sb[6:0], serial_data_in};
          bit_cnt        <= bit_cnt + 4'd1;
          serial_clk_out <= 1'b1;
          if (bit_cnt == 4'd7) begin
            state   <= IDLE;
            irq     <= 1'b1;
            phase   <= 10'd0;
            bit_cnt <= 4'd0;
          end
        end
      end

      // CPU writes are applied last so they win over same-edge shifts
      if (wr_sb)
        sb <= mem_data_in;
      if (wr_sc) begin
        sc0            <= mem_data_in[0];
        state          <= mem_data_in[7] ? SHIFT : IDLE;
        phase          <= 10'd0;
        bit_cnt        <= 4'd0;
        serial_clk_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_port.sv
// Randomized and directed bench for serial_port, checked every cycle against a
// timeline-based behavioural model of the SB/SC registers and shift pins.
module tb_serial_port;

  localparam int DIV = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr = 16'h0000;
  logic        mem_enable = 1'b0;
  logic        mem_write = 1'b0;
  logic [7:0]  mem_data_in = 8'h00;
  logic [7:0]  mem_data_out;
  logic        irq;
  logic        serial_clk_out;
  logic        serial_clk_in = 1'b1;
  logic        serial_data_out;
  logic        serial_data_in;
  logic        sdi_drv = 1'b1;
  logic        loopback = 1'b0;

  assign serial_data_in = loopback ? serial_data_out : sdi_drv;

  serial_port #(.CLOCK_DIV(DIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_enable     (mem_enable),
    .mem_write      (mem_write),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .irq            (irq),
    .serial_clk_out (serial_clk_out),
    .serial_clk_in  (serial_clk_in),
    .serial_data_out(serial_data_out),
    .serial_data_in (serial_data_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Model state: transfer position is derived from the cycle count since start
  int         cyc = 0;
  int         m_start = 0;
  logic [7:0] m_sb = 8'h00;
  logic       m_sc7 = 1'b0;
  logic       m_sc0 = 1'b0;
  logic [7:0] m_rd = 8'h00;
  logic       m_irq = 1'b0;
  logic       m_clk = 1'b1;
  logic       m_dout = 1'b1;
  logic       m_ext_busy = 1'b0;

  task automatic model_step();
    logic [7:0] sb0;
    logic       sc7_0, sc0_0;
    int         d, ph, k;
    cyc++;
    m_irq = 1'b0;
    if (reset) begin
      m_sb = 8'h00; m_sc7 = 1'b0; m_sc0 = 1'b0; m_rd = 8'h00;
      m_clk = 1'b1; m_dout = 1'b1; m_ext_busy = 1'b0;
      return;
    end
    sb0 = m_sb; sc7_0 = m_sc7; sc0_0 = m_sc0;
    if (m_sc7 && m_sc0) begin
      d  = cyc - m_start - 1;
      ph = d % DIV;
      k  = d / DIV;
      if (ph == 0) begin
        m_clk = 1'b0;
        m_dout = m_sb[7];
      end else if (ph == DIV / 2) begin
        m_sb  = {m_sb[6:0], serial_data_in};
        m_clk = 1'b1;
        if (k == 7) begin
          m_sc7 = 1'b0;
          m_irq = 1'b1;
        end
      end
    end
    if (mem_enable && mem_write && mem_addr == 16'hFF01)
      m_sb = mem_data_in;
    if (mem_enable && mem_write && mem_addr == 16'hFF02) begin
      m_sc7 = mem_data_in[7];
      m_sc0 = mem_data_in[0];
      m_start = cyc;
      m_clk = 1'b1;
      m_ext_busy = mem_data_in[7] && !mem_data_in[0];
    end
    if (mem_enable && !mem_write && mem_addr == 16'hFF01)
      m_rd = sb0;
    if (mem_enable && !mem_write && mem_addr == 16'hFF02)
      m_rd = {sc7_0, 6'b111111, sc0_0};
  endtask

  // Pin monitor
  logic       prev_clk = 1'b1;
  logic [7:0] fall_bits = 8'h00;
  int         rise_cnt = 0;
  int         rec_n = 0;
  int         rec_t[16];
  int         irq_cnt = 0;
  int         irq_last = 0;

  always @(posedge clk) begin
    model_step();
    #1;
    check("mem_data_out", 32'(mem_data_out), 32'(m_rd));
    check("serial_clk_out", 32'(serial_clk_out), 32'(m_clk));
    if (!m_ext_busy) begin
      check("irq", 32'(irq), 32'(m_irq));
      check("serial_data_out", 32'(serial_data_out), 32'(m_dout));
    end
    if (prev_clk && !serial_clk_out)
      fall_bits = {fall_bits[6:0], serial_data_out};
    if (!prev_clk && serial_clk_out) begin
      if (rec_n < 16) rec_t[rec_n] = cyc;
      rec_n++;
      rise_cnt++;
    end
    if (irq === 1'b1) begin
      irq_cnt++;
      irq_last = cyc;
    end
    prev_clk = serial_clk_out;
  end

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic en);
    @(negedge clk);
    mem_addr = a; mem_data_in = d; mem_enable = en; mem_write = 1'b1;
    @(negedge clk);
    mem_enable = 1'b0; mem_write = 1'b0;
    $display("wr %h <= %h en=%0b", a, d, en);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    mem_addr = a; mem_enable = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    mem_enable = 1'b0;
    d = mem_data_out;
    $display("rd %h -> %h", a, d);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && m_sc7; i++) @(negedge clk);
    check("transfer_timeout", 32'(m_sc7), 32'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic ext_pulse_idle();
    @(negedge clk); serial_clk_in = 1'b0;
    repeat (20) @(negedge clk); serial_clk_in = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic ext_xfer(input logic [7:0] bits);
    logic [7:0] exp;
    logic       last;
    int         c0;
    exp = m_sb; c0 = irq_cnt; last = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); serial_clk_in = 1'b0;
      repeat (10) @(negedge clk);
      check("ext_data_out", 32'(serial_data_out), 32'(exp[7]));
      last = exp[7];
      sdi_drv = bits[i];
      repeat (10) @(negedge clk); serial_clk_in = 1'b1;
      exp = {exp[6:0], bits[i]};
      repeat (20) @(negedge clk);
    end
    check("ext_irq_count", 32'(irq_cnt - c0), 32'(1));
    check("ext_clk_out_idle", 32'(serial_clk_out), 32'(1));
    m_sb = exp; m_sc7 = 1'b0; m_dout = last; m_ext_busy = 1'b0;
    $display("ext transfer bits=%h sb=%h", bits, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         c0, r0;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and decode
    bus_read(16'hFF02, d); check("rst_sc", 32'(d), 32'h7E);
    bus_read(16'hFF01, d); check("rst_sb", 32'(d), 32'h00);
    check("rst_clk_out", 32'(serial_clk_out), 32'(1));
    check("rst_data_out", 32'(serial_data_out), 32'(1));
    bus_write(16'hFF03, 8'h55, 1'b1);
    bus_write(16'hFF00, 8'hAA, 1'b1);
    bus_write(16'hFF01, 8'h77, 1'b0);
    bus_write(16'hFF02, 8'h81, 1'b0);
    bus_read(16'hFF00, d); check("decode_rd_hold", 32'(d), 32'h00);
    bus_read(16'hFF01, d); check("decode_sb", 32'(d), 32'h00);
    bus_read(16'hFF02, d); check("decode_sc", 32'(d), 32'h7E);

    // Internal transfer of 0xA5 with data_in tied high
    bus_write(16'hFF01, 8'hA5, 1'b1);
    sdi_drv = 1'b1; rec_n = 0; fall_bits = 8'h00; c0 = irq_cnt;
    bus_write(16'hFF02, 8'h81, 1'b1);
    wait_idle(5000);
    check("a5_bits", 32'(fall_bits), 32'hA5);
    check("a5_rises", 32'(rec_n), 32'(8));
    for (int i = 1; i < 8; i++)
      check("a5_rise_spacing", 32'(rec_t[i] - rec_t[i-1]), 32'(512));
    check("a5_irq_count", 32'(irq_cnt - c0), 32'(1));
    check("a5_irq_time", 32'(irq_last - m_start), 32'(3841));
    bus_read(16'hFF01, d); check("a5_sb", 32'(d), 32'hFF);
    bus_read(16'hFF02, d); check("a5_sc", 32'(d), 32'h7F);

    // Internal loopback
    loopback = 1'b1;
    bus_write(16'hFF01, 8'h3C, 1'b1);
    bus_write(16'hFF02, 8'h81, 1'b1);
    wait_idle(5000);
    loopback = 1'b0;
    bus_read(16'hFF01, d); check("loop_sb", 32'(d), 32'h3C);

    // External mode: no shifting while idle, then 8 pulses of ones
    bus_write(16'hFF01, 8'h00, 1'b1);
    bus_write(16'hFF02, 8'h00, 1'b1);
    sdi_drv = 1'b1;
    ext_pulse_idle();
    bus_read(16'hFF01, d); check("ext_idle_sb", 32'(d), 32'h00);
    bus_write(16'hFF02, 8'h80, 1'b1);
    ext_xfer(8'hFF);
    bus_read(16'hFF01, d); check("ext_sb", 32'(d), 32'hFF);
    bus_read(16'hFF02, d); check("ext_sc", 32'(d), 32'h7E);

    // Abort after 3 shifts
    bus_write(16'hFF01, 8'h5A, 1'b1);
    r0 = rise_cnt; c0 = irq_cnt;
    bus_write(16'hFF02, 8'h81, 1'b1);
    for (int i = 0; i < 3000 && rise_cnt - r0 < 3; i++) @(negedge clk);
    check("abort_3_shifts", 32'(rise_cnt - r0), 32'(3));
    repeat (10) @(negedge clk);
    bus_write(16'hFF02, 8'h01, 1'b1);
    repeat (1500) @(negedge clk);
    check("abort_no_irq", 32'(irq_cnt - c0), 32'(0));
    check("abort_clk_idle", 32'(serial_clk_out), 32'(1));
    bus_read(16'hFF02, d); check("abort_sc", 32'(d), 32'h7F);

    // Reset mid-transfer
    c0 = irq_cnt;
    bus_write(16'hFF02, 8'h81, 1'b1);
    repeat (1000) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_clk_out", 32'(serial_clk_out), 32'(1));
    check("rst2_data_out", 32'(serial_data_out), 32'(1));
    check("rst2_rd", 32'(mem_data_out), 32'h00);
    repeat (3000) @(negedge clk);
    check("rst2_no_irq", 32'(irq_cnt - c0), 32'(0));
    bus_read(16'hFF02, d); check("rst2_sc", 32'(d), 32'h7E);
    bus_read(16'hFF01, d); check("rst2_sb", 32'(d), 32'h00);

    // Randomized internal transfers with random data, reads and SB overwrites
    for (int t = 0; t < 4; t++) begin
      int r;
      c0 = irq_cnt;
      bus_write(16'hFF01, 8'($urandom), 1'b1);
      bus_write(16'hFF02, 8'h81, 1'b1);
      for (int i = 0; i < 5000 && m_sc7; i++) begin
        @(negedge clk);
        sdi_drv = 1'($urandom);
        r = int'($urandom_range(0, 299));
        mem_enable = 1'b0; mem_write = 1'b0;
        if (r == 0) begin
          mem_addr = 16'hFF01; mem_data_in = 8'($urandom);
          mem_enable = 1'b1; mem_write = 1'b1;
        end else if (r < 4) begin
          mem_addr = ($urandom_range(0, 1) == 0) ? 16'hFF01 : 16'hFF02;
          mem_enable = 1'b1;
        end
      end
      @(negedge clk);
      mem_enable = 1'b0; mem_write = 1'b0;
      check("rand_timeout", 32'(m_sc7), 32'(0));
      repeat (3) @(negedge clk);
      check("rand_irq_count", 32'(irq_cnt - c0), 32'(1));
      bus_read(16'hFF01, d); check("rand_sb", 32'(d), 32'(m_sb));
      $display("random transfer %0d sb=%h", t, d);
    end

    // Randomized external transfer
    bus_write(16'hFF01, 8'($urandom), 1'b1);
    bus_write(16'hFF02, 8'h80, 1'b1);
    ext_xfer(8'($urandom));
    bus_read(16'hFF01, d); check("rand_ext_sb", 32'(d), 32'(m_sb));

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
